// File: rtl/divider_64.sv
// Iterative unsigned divider: one quotient bit per clock via restoring shift-subtract.
// Start/busy/done handshake lets the control unit stall instead of carrying a combinational divide.
module divider_64 #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FINISH
  } state_t;

  state_t state;
  state_t state_next;

  logic [WIDTH-1:0] divisor_q;
  logic [WIDTH-1:0] q_work;
  logic [WIDTH-1:0] q_next;
  logic [WIDTH:0]   r_work;
  logic [WIDTH:0]   r_shift;
  logic [WIDTH:0]   r_diff;
  logic [WIDTH:0]   r_next;
  logic [WIDTH:0]   sub_operand;
  logic [CW-1:0]    count;
  logic             carry;
  logic             accept;
  logic             divisor_zero;
  logic             last_iter;

  assign accept       = start && (state != RUN);
  assign divisor_zero = (divisor == '0);
  assign last_iter    = (count == CW'(1));
  assign busy         = (state == RUN);
  assign done         = (state == FINISH);

  // One iteration: shift the next dividend bit into R, then trial-subtract the
  // divisor as an add of its two's complement, rippled bit by bit.
  always_comb begin
    r_shift     = {r_work[WIDTH-1:0], q_work[WIDTH-1]};
    sub_operand = ~{1'b0, divisor_q};
    r_diff      = '0;
    // NOTE: blocking assignments here model the carry rippling through the
    // chain within one evaluation; sequential state below uses <= only.
    carry       = 1'b1;
    for (int i = 0; i <= WIDTH; i++) begin
      r_diff[i] = r_shift[i] ^ sub_operand[i] ^ carry;
      carry     = (r_shift[i] & sub_operand[i]) | (carry & (r_shift[i] ^ sub_operand[i]));
    end
    // Carry-out set means R' >= divisor, so the subtraction is kept.
    q_next = {q_work[WIDTH-2:0], carry};
    r_next = carry ? r_diff : r_shift;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    // NOTE: default first so every path assigns state_next and no latch is inferred.
    state_next = state;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_next = divisor_zero ? FINISH : RUN;
        end
      end
      RUN: begin
        if (last_iter) begin
          state_next = FINISH;
        end
      end
      FINISH: begin
        if (start) begin
          state_next = divisor_zero ? FINISH : RUN;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: working registers carry no reset; they are always loaded on the
  // accepting edge before being read, and the state register guards their use.
  always_ff @(posedge clk) begin
    if (accept) begin
      divisor_q <= divisor;
      q_work    <= dividend;
      r_work    <= '0;
      count     <= CW'(WIDTH);
    end else if (state == RUN) begin
      q_work <= q_next;
      r_work <= r_next;
      count  <= count - CW'(1);
    end
  end

  // Visible results move only on the edge entering FINISH; divide-by-zero
  // returns quotient 0 and the dividend as remainder without iterating.
  always_ff @(posedge clk) begin
    if (reset) begin
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (accept) begin
      div_by_zero <= divisor_zero;
      if (divisor_zero) begin
        quotient  <= '0;
        remainder <= dividend;
      end
    end else if ((state == RUN) && last_iter) begin
      quotient  <= q_next;
      remainder <= r_next[WIDTH-1:0];
    end
  end

endmodule

// File: tb/tb_divider_64.sv
// Directed and random checks of divider_64 using a scoreboard of expected results
// pushed at start and popped at done.
module tb_divider_64;

  localparam int W = 64;

  typedef struct {
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic [W-1:0] quo;
    logic [W-1:0] rem;
    logic         dz;
  } exp_t;

  logic         clk;
  logic         reset;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int n_vec;
  int n_fail;
  exp_t sb[$];

  divider_64 #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive start for one edge (E0) and record the expected result.
  task automatic start_div(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    e.dividend = a;
    e.divisor  = b;
    if (b == '0) begin
      e.quo = '0;
      e.rem = a;
      e.dz  = 1'b1;
    end else begin
      e.quo = a / b;
      e.rem = a % b;
      e.dz  = 1'b0;
    end
    sb.push_back(e);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    tick();
    start = 1'b0;
  endtask

  // Wait (bounded) for done, checking latency and busy cycles, then compare results.
  task automatic wait_done(input string tag, input int exp_lat, input int exp_busy);
    int cycles;
    int busy_cycles;
    exp_t e;
    logic [2*W-1:0] recon;
    cycles      = 0;
    busy_cycles = 0;
    while (!done && cycles < exp_lat + 10) begin
      if (busy) busy_cycles++;
      tick();
      cycles++;
    end
    check({tag, "_latency"}, W'(cycles), W'(exp_lat));
    check({tag, "_busy_cycles"}, W'(busy_cycles), W'(exp_busy));
    check({tag, "_busy_at_done"}, W'(busy), W'(0));
    check({tag, "_sb_nonempty"}, W'(sb.size() != 0), W'(1));
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check({tag, "_quotient"}, quotient, e.quo);
      check({tag, "_remainder"}, remainder, e.rem);
      check({tag, "_div_by_zero"}, W'(div_by_zero), W'(e.dz));
      if (!e.dz) begin
        recon = 128'(quotient) * 128'(e.divisor) + 128'(remainder);
        check({tag, "_identity_lo"}, recon[W-1:0], e.dividend);
        check({tag, "_identity_hi"}, recon[2*W-1:W], '0);
        check({tag, "_rem_lt_div"}, W'(remainder < e.divisor), W'(1));
      end
    end
  endtask

  initial begin
    n_vec    = 0;
    n_fail   = 0;
    reset    = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    tick();
    tick();
    reset = 1'b0;
    check("reset_busy", W'(busy), W'(0));
    check("reset_done", W'(done), W'(0));
    check("reset_quotient", quotient, '0);
    check("reset_remainder", remainder, '0);
    check("reset_dz", W'(div_by_zero), W'(0));

    // A start coinciding with reset must be dropped.
    reset    = 1'b1;
    start    = 1'b1;
    dividend = 64'd10;
    divisor  = 64'd2;
    tick();
    reset = 1'b0;
    start = 1'b0;
    check("start_in_reset_busy", W'(busy), W'(0));
    tick();
    check("start_in_reset_busy2", W'(busy), W'(0));
    check("start_in_reset_done", W'(done), W'(0));

    start_div(64'd100, 64'd7);
    wait_done("d100_7", W, W);
    tick();
    check("d100_7_done_pulse", W'(done), W'(0));

    start_div('1, 64'd1);
    wait_done("dmax_1", W, W);
    // Back-to-back: start issued during the done cycle.
    start_div(64'd3, 64'd10);
    wait_done("d3_10_b2b", W, W);

    tick();
    start_div(64'd5, 64'd0);
    wait_done("d5_0", 0, 0);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("d5_0_hold_done", W'(done), W'(0));
      check("d5_0_hold_busy", W'(busy), W'(0));
      check("d5_0_hold_quotient", quotient, '0);
      check("d5_0_hold_remainder", remainder, 64'd5);
      check("d5_0_hold_dz", W'(div_by_zero), W'(1));
    end

    // Back-to-back divide-by-zero keeps done high on consecutive cycles.
    start_div(64'd7, 64'd0);
    wait_done("d7_0", 0, 0);
    start_div(64'd9, 64'd0);
    wait_done("d9_0_b2b", 0, 0);
    tick();

    // Start during RUN is ignored even with changed operands.
    start_div(64'd1000, 64'd3);
    for (int i = 0; i < 19; i++) tick();
    start    = 1'b1;
    dividend = 64'd9;
    divisor  = 64'd9;
    tick();
    start = 1'b0;
    wait_done("d1000_3", W - 20, W - 20);

    // Reset mid-run discards the division.
    tick();
    start_div(64'd500, 64'd4);
    void'(sb.pop_back());
    for (int i = 0; i < 29; i++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midrun_reset_busy", W'(busy), W'(0));
    check("midrun_reset_done", W'(done), W'(0));
    check("midrun_reset_quotient", quotient, '0);
    check("midrun_reset_remainder", remainder, '0);
    check("midrun_reset_dz", W'(div_by_zero), W'(0));
    start_div(64'd81, 64'd9);
    wait_done("d81_9", W, W);

    // Random sweep, issued back to back from each done cycle.
    for (int i = 0; i < 1000; i++) begin
      logic [W-1:0] a;
      logic [W-1:0] b;
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      case (i % 4)
        0: ;
        1: b = W'($urandom_range(1, 1000));
        2: begin
          b[W-1] = 1'b1;
          a      = a >> $urandom_range(1, 63);
        end
        default: begin
          a[W-1] = 1'b1;
          b      = b >> $urandom_range(0, 63);
        end
      endcase
      if (b == '0) b = 64'd1;
      start_div(a, b);
      wait_done("rand", W, W);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
